ccff_chain_loader: RTL and testbench
====================================

// Module: ccff_chain_loader
// PURPOSE
//  Drives the configuration chain of a tile (ccff_head in, ccff_tail out) from a word-wide host stream.
//  Serializes bitstream words MSB-first onto ccff_head with a per-bit shift enable for the gated chain clock.
//  Optional second pass compares returning ccff_tail bits against a resent stream to detect chain faults.
//  Sits between the bitstream host/DMA and the first ccff_head of the fabric.
// PARAMETERS
//  WORD_W     32  bits per host word
//  CHAIN_LEN  44  config bits in the chain (sb_0__0_: 16x2 + 4x3)
//  CNT_W      16  width of bit counter; CHAIN_LEN must be < 2**CNT_W
//  VERIFY     1   1: run readback pass after load pass; 0: load only
// PORTS
//  prog_clk       in   1       configuration clock; all state on rising edge
//  pReset         in   1       asynchronous, active-high reset
//  start          in   1       one-cycle pulse; begins a load when IDLE
//  word_data      in   WORD_W  bitstream word, bit WORD_W-1 shifted first
//  word_valid     in   1       host word valid
//  word_ready     out  1       loader accepts word_data this cycle
//  ccff_head      out  1       serial bit to chain head (registered)
//  ccff_shift_en  out  1       chain captures ccff_head on next prog_clk edge (registered)
//  ccff_tail      in   1       serial bit returning from chain tail
//  busy           out  1       high from start acceptance until DONE
//  done           out  1       one-cycle pulse when operation completes
//  readback_err   out  1       sticky; set on any pass-2 mismatch, cleared by next start
//  bit_count      out  CNT_W   bits shifted in current pass
// BEHAVIOUR
//  Reset (async, pReset=1): state IDLE; word_ready, ccff_head, ccff_shift_en, busy, done,
//   readback_err = 0; bit_count = 0; pass = 1; shift register and remain counter cleared.
//  Deassert of pReset is synchronous in effect: first transition one edge after release.
//  FSM: IDLE -> FETCH -> SHIFT -> (FETCH | PASSEND) -> FETCH(pass2) ... -> DONE -> IDLE.
//  IDLE: start=1 -> FETCH, busy=1, bit_count=0, pass=1, readback_err=0. start ignored elsewhere.
//  FETCH: word_ready=1; handshake = word_valid & word_ready; on handshake load shreg, set
//   remain = min(WORD_W, CHAIN_LEN-bit_count), go SHIFT. No handshake -> stay, shift_en=0.
//  SHIFT: each cycle ccff_head<=shreg[MSB], ccff_shift_en<=1, shreg<<=1, bit_count+=1, remain-=1.
//   remain reaching 0: bit_count==CHAIN_LEN -> PASSEND, else FETCH. Bits of a final partial
//   word beyond CHAIN_LEN are discarded (word still consumed).
//  Stalls: ccff_shift_en=0 in every non-SHIFT cycle; chain holds; ccff_head holds last value.
//  Throughput: 1 bit/cycle while shifting; 1 bubble cycle per word (FETCH).
//  PASSEND: VERIFY=1 and pass=1 -> pass=2, bit_count=0, FETCH; else DONE.
//  Pass 2: host resends identical stream. In each cycle with ccff_shift_en=1 and pass=2,
//   ccff_tail (holds pass-1 bit of same index) is compared with ccff_head;
//   mismatch sets readback_err at next edge. Pass 2 leaves the chain holding the same config.
//  DONE: done=1 for exactly one cycle, busy=0 same cycle as done; return IDLE.
//  Words per pass = ceil(CHAIN_LEN/WORD_W); total cycles ~ CHAIN_LEN + words (+ host stalls).
//  pReset mid-operation: immediate abort, ccff_shift_en=0 asynchronously; chain content undefined
//   and must be reloaded. word_ready never high outside FETCH.
// TESTING
//  T1 Load, VERIFY=0, CHAIN_LEN=44, WORD_W=32: words 0xA5A5_A5A5, 0xC3F0_0000 -> 44 shift_en
//   pulses, head sequence = 32 bits of A5A5A5A5 then 1100_0011_1111 MSB-first; done pulse; bit_count=44.
//  T2 Host stall: word_valid low 5 cycles between words -> shift_en low exactly 5+1 cycles,
//   chain model content identical to T1.
//  T3 Readback pass, VERIFY=1, chain model = 44-bit shift reg: resend same words -> readback_err=0,
//   88 total shifts, one done pulse.
//  T4 Fault: chain model bit 17 stuck-at-0, stream all ones -> readback_err=1 after pass 2, stays 1
//   until next start.
//  T5 Reset mid-SHIFT (bit_count=20): assert pReset -> ccff_shift_en=0, busy=0 same cycle; new start
//   reloads cleanly, bit_count restarts at 0.
//  T6 start asserted while busy and during DONE cycle -> ignored; exactly one done per accepted start.

Source files
------------

// File: rtl/ccff_chain_loader_if.sv
// Host bitstream word stream into the chain loader.
// A word transfers on a clock edge where word_valid and word_ready are both high.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// Serializes host words MSB-first onto a tile configuration chain (ccff_head/ccff_tail),
// with an optional second pass that checks the returning tail bits against a resent stream.
module ccff_chain_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 44,
  parameter int CNT_W     = 16,
  parameter bit VERIFY    = 1'b1
) (
  input  logic               i_prog_clk,
  input  logic               i_pReset,
  input  logic               i_start,
  ccff_chain_loader_if.slave host,
  output logic               o_ccff_head,
  output logic               o_ccff_shift_en,
  input  logic               i_ccff_tail,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_readback_err,
  output logic [CNT_W-1:0]   o_bit_count
);

  localparam int REM_W = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SHIFT, S_PASSEND, S_DONE
  } state_t;

  state_t             r_state, w_next;
  logic [WORD_W-1:0]  r_shreg;
  logic [REM_W-1:0]   r_remain;
  logic [CNT_W-1:0]   r_bit_count;
  logic               r_pass2;
  logic               r_head;
  logic               r_shift_en;
  logic               r_err;

  logic               w_hs;
  logic [CNT_W-1:0]   w_left;
  logic [REM_W-1:0]   w_load_remain;
  logic               w_last_bit;

  assign w_hs          = (r_state == S_FETCH) && host.word_valid;
  assign w_left        = CNT_W'(CHAIN_LEN) - r_bit_count;
  // The final word of a pass may be partial; its excess low bits are never shifted.
  assign w_load_remain = (w_left >= CNT_W'(WORD_W)) ? REM_W'(WORD_W) : REM_W'(w_left);
  assign w_last_bit    = (r_remain == REM_W'(1));

  always_ff @(posedge i_prog_clk or posedge i_pReset) begin
    if (i_pReset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (i_start) w_next = S_FETCH;
      S_FETCH:   if (w_hs) w_next = S_SHIFT;
      S_SHIFT:   if (w_last_bit)
                   w_next = (r_bit_count == CNT_W'(CHAIN_LEN - 1)) ? S_PASSEND : S_FETCH;
      S_PASSEND: w_next = (VERIFY && !r_pass2) ? S_FETCH : S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_prog_clk or posedge i_pReset) begin
    if (i_pReset) begin
      r_shreg     <= '0;
      r_remain    <= '0;
      r_bit_count <= '0;
      r_pass2     <= 1'b0;
      r_head      <= 1'b0;
      r_shift_en  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_shift_en <= 1'b0;
      // Tail still carries the pass-1 bit of the index now presented on head.
      if (r_shift_en && r_pass2 && (i_ccff_tail != r_head))
        r_err <= 1'b1;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_bit_count <= '0;
          r_pass2     <= 1'b0;
          r_err       <= 1'b0;
        end
        S_FETCH: if (w_hs) begin
          r_shreg  <= host.word_data;
          r_remain <= w_load_remain;
        end
        S_SHIFT: begin
          r_head      <= r_shreg[WORD_W-1];
          r_shift_en  <= 1'b1;
          r_shreg     <= {r_shreg[WORD_W-2:0], 1'b0};
          r_bit_count <= r_bit_count + 1'b1;
          r_remain    <= r_remain - 1'b1;
        end
        S_PASSEND: if (VERIFY && !r_pass2) begin
          r_pass2     <= 1'b1;
          r_bit_count <= '0;
        end
        default: ;
      endcase
    end
  end

  assign host.word_ready = (r_state == S_FETCH);
  assign o_ccff_head     = r_head;
  assign o_ccff_shift_en = r_shift_en;
  assign o_busy          = (r_state == S_FETCH) || (r_state == S_SHIFT) || (r_state == S_PASSEND);
  assign o_done          = (r_state == S_DONE);
  assign o_readback_err  = r_err;
  assign o_bit_count     = r_bit_count;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench: a load-only loader and a verifying loader, each driving a 44-bit chain model.
module tb_ccff_chain_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  start = '0;
  logic [1:0]  vld = '0;
  logic [31:0] wdata [2];
  logic [1:0]  head, sen, busy, done, err, rdy;
  logic [15:0] bc0, bc1;
  logic [43:0] chain0, chain1, fmask;
  logic        fault = 1'b0;

  int cyc = 0, shifts0 = 0, shifts1 = 0, dones0 = 0, dones1 = 0;
  int sidx0 [0:511];
  int n_chk = 0, n_fail = 0;

  localparam logic [43:0] EXP_CHAIN = 44'hA5A5A5A5C3F;

  ccff_chain_loader_if #(.WORD_W(32)) if0 ();
  ccff_chain_loader_if #(.WORD_W(32)) if1 ();

  assign if0.word_data  = wdata[0];
  assign if0.word_valid = vld[0];
  assign rdy[0]         = if0.word_ready;
  assign if1.word_data  = wdata[1];
  assign if1.word_valid = vld[1];
  assign rdy[1]         = if1.word_ready;
  assign fmask          = fault ? (44'd1 << 17) : 44'd0;

  ccff_chain_loader #(.WORD_W(32), .CHAIN_LEN(44), .CNT_W(16), .VERIFY(1'b0)) u_dut0 (
    .i_prog_clk(clk), .i_pReset(rst), .i_start(start[0]), .host(if0),
    .o_ccff_head(head[0]), .o_ccff_shift_en(sen[0]), .i_ccff_tail(chain0[43]),
    .o_busy(busy[0]), .o_done(done[0]), .o_readback_err(err[0]), .o_bit_count(bc0));

  ccff_chain_loader #(.WORD_W(32), .CHAIN_LEN(44), .CNT_W(16), .VERIFY(1'b1)) u_dut1 (
    .i_prog_clk(clk), .i_pReset(rst), .i_start(start[1]), .host(if1),
    .o_ccff_head(head[1]), .o_ccff_shift_en(sen[1]), .i_ccff_tail(chain1[43]),
    .o_busy(busy[1]), .o_done(done[1]), .o_readback_err(err[1]), .o_bit_count(bc1));

  always #5 clk = ~clk;

  // Chain models and event counters
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sen[0]) begin
      sidx0[shifts0] <= cyc;
      shifts0 <= shifts0 + 1;
      chain0  <= {chain0[42:0], head[0]};
    end
    if (sen[1]) begin
      shifts1 <= shifts1 + 1;
      chain1  <= {chain1[42:0], head[1]} & ~fmask;
    end
    if (done[0]) dones0 <= dones0 + 1;
    if (done[1]) dones1 <= dones1 + 1;
  end

  task automatic pulse_start(input int d);
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
  endtask

  task automatic wait_ready(input int d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rdy[d]) begin ok = 1'b1; break; end
    end
  endtask

  task automatic push(input int d, input logic [31:0] w, input int stall);
    bit ok;
    if (stall > 0) begin
      wait_ready(d, ok);
      repeat (stall) @(posedge clk);
      #1;
    end
    wdata[d] = w;
    vld[d]   = 1'b1;
    wait_ready(d, ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL push_timeout d=%0d: word_ready got 0, expected 1 within 500 cycles", d);
    end
    @(posedge clk); #1;
    vld[d] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (done[d]) begin ok = 1'b1; break; end
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL done_timeout d=%0d: done got 0, expected 1 within 500 cycles", d);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if ({head[d], sen[d], busy[d], done[d], err[d], rdy[d]} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_outs d=%0d: got %b, expected 000000", d,
                 {head[d], sen[d], busy[d], done[d], err[d], rdy[d]});
      end
    end
    n_chk++;
    if ({bc0, bc1} !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_bitcount: got %0d/%0d, expected 0/0", bc0, bc1);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (busy !== 2'b00 || rdy !== 2'b00) begin
      n_fail++;
      $display("FAIL post_reset_idle: busy=%b ready=%b, expected 00/00", busy, rdy);
    end
  endtask

  // Load-only pass; stall = FETCH cycles held with word_valid low before the second word
  task automatic run_load0(input string tag, input int stall);
    int s0 = shifts0, d0 = dones0, gap;
    pulse_start(0);
    n_chk++;
    if (busy[0] !== 1'b1 || bc0 !== 16'd0) begin
      n_fail++;
      $display("FAIL %s_start: busy=%b bit_count=%0d, expected 1/0", tag, busy[0], bc0);
    end
    push(0, 32'hA5A5A5A5, 0);
    push(0, 32'hC3F00000, stall);
    wait_done(0);
    n_chk++;
    if (busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_busy_at_done: got %b, expected 0", tag, busy[0]);
    end
    @(posedge clk); #1;
    n_chk++;
    if (shifts0 - s0 !== 44 || dones0 - d0 !== 1) begin
      n_fail++;
      $display("FAIL %s_counts: shifts=%0d dones=%0d, expected 44/1", tag, shifts0 - s0, dones0 - d0);
    end
    n_chk++;
    if (chain0 !== EXP_CHAIN || bc0 !== 16'd44) begin
      n_fail++;
      $display("FAIL %s_chain: chain=%h bit_count=%0d, expected %h/44", tag, chain0, bc0, EXP_CHAIN);
    end
    gap = sidx0[s0 + 32] - sidx0[s0 + 31] - 1;
    n_chk++;
    if (gap !== stall + 1) begin
      n_fail++;
      $display("FAIL %s_gap: shift_en low %0d cycles, expected %0d", tag, gap, stall + 1);
    end
  endtask

  task automatic test_load;       run_load0("t1", 0); endtask
  task automatic test_host_stall; run_load0("t2", 5); endtask

  // Two-pass load on the verifying loader, same words each pass
  task automatic run_verify(input string tag, input logic [31:0] w0, input logic [31:0] w1,
                            input logic exp_err);
    int s1 = shifts1, d1 = dones1;
    pulse_start(1);
    n_chk++;
    if (err[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_err_cleared: got %b, expected 0", tag, err[1]);
    end
    for (int p = 0; p < 2; p++) begin
      push(1, w0, 0);
      push(1, w1, 0);
    end
    wait_done(1);
    @(posedge clk); #1;
    n_chk++;
    if (shifts1 - s1 !== 88 || dones1 - d1 !== 1) begin
      n_fail++;
      $display("FAIL %s_counts: shifts=%0d dones=%0d, expected 88/1", tag, shifts1 - s1, dones1 - d1);
    end
    n_chk++;
    if (err[1] !== exp_err) begin
      n_fail++;
      $display("FAIL %s_readback_err: got %b, expected %b", tag, err[1], exp_err);
    end
  endtask

  task automatic test_readback;
    fault = 1'b0;
    run_verify("t3", 32'hA5A5A5A5, 32'hC3F00000, 1'b0);
    n_chk++;
    if (chain1 !== EXP_CHAIN || bc1 !== 16'd44) begin
      n_fail++;
      $display("FAIL t3_chain: chain=%h bit_count=%0d, expected %h/44", chain1, bc1, EXP_CHAIN);
    end
  endtask

  task automatic test_fault;
    fault = 1'b1;
    run_verify("t4", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    fault = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_chk++;
    if (err[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL t4_sticky: got %b, expected 1", err[1]);
    end
    run_verify("t4_clear", 32'hA5A5A5A5, 32'hC3F00000, 1'b0);
  endtask

  task automatic test_reset_mid;
    bit ok = 1'b0;
    pulse_start(0);
    push(0, 32'hA5A5A5A5, 0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bc0 == 16'd20) begin ok = 1'b1; break; end
    end
    n_chk++;
    if (!ok || sen[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_reach20: bit_count=%0d shift_en=%b, expected 20/1", bc0, sen[0]);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (sen[0] !== 1'b0 || busy[0] !== 1'b0 || bc0 !== 16'd0) begin
      n_fail++;
      $display("FAIL t5_abort: shift_en=%b busy=%b bit_count=%0d, expected 0/0/0", sen[0], busy[0], bc0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_load0("t5_reload", 0);
  endtask

  task automatic test_back_to_back;
    int d1 = dones1;
    pulse_start(1);
    push(1, 32'hA5A5A5A5, 0);
    pulse_start(1);
    n_chk++;
    if (busy[1] !== 1'b1 || bc1 === 16'd0) begin
      n_fail++;
      $display("FAIL t6_start_busy: busy=%b bit_count=%0d, expected 1/nonzero", busy[1], bc1);
    end
    push(1, 32'hC3F00000, 0);
    push(1, 32'hA5A5A5A5, 0);
    push(1, 32'hC3F00000, 0);
    wait_done(1);
    start[1] = 1'b1;
    @(posedge clk); #1;
    start[1] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_chk++;
    if (busy[1] !== 1'b0 || rdy[1] !== 1'b0 || bc1 !== 16'd44 || dones1 - d1 !== 1) begin
      n_fail++;
      $display("FAIL t6_ignored: busy=%b ready=%b bit_count=%0d dones=%0d, expected 0/0/44/1",
               busy[1], rdy[1], bc1, dones1 - d1);
    end
    n_chk++;
    if (err[1] !== 1'b0 || chain1 !== EXP_CHAIN) begin
      n_fail++;
      $display("FAIL t6_chain: err=%b chain=%h, expected 0/%h", err[1], chain1, EXP_CHAIN);
    end
  endtask

  initial begin
    wdata[0] = '0;
    wdata[1] = '0;
    test_reset();
    test_load();
    test_host_stall();
    test_readback();
    test_fault();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
